// File: rtl/mult_div_unit_pkg.sv
// Shared types and sizing for the sequential multiply/divide unit.
// The state set and counter sizing are common to the top, the interface and the bench.
package mult_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MULT   = 3'd1,
    DIV    = 3'd2,
    FINISH = 3'd3,
    DZERO  = 3'd4
  } state_t;

  // Holds the values 0..w, so one extra bit beyond clog2(w).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the multicycle control unit (master)
// and the multiply/divide unit (slave).
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a_in, b_in,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit_signfix.sv
// Sign handling shared by multiply and divide: operand magnitudes at capture
// and two's complement correction of the raw unsigned result at commit.
module mult_div_signfix
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0]   a_in,
  input  logic signed [WIDTH-1:0]   b_in,
  output logic        [WIDTH-1:0]   mag_a,
  output logic        [WIDTH-1:0]   mag_b,
  output logic                      a_neg,
  output logic                      b_neg,
  input  logic                      is_div,
  input  logic                      neg_a,
  input  logic                      neg_b,
  input  logic        [2*WIDTH-1:0] raw,
  output logic        [WIDTH-1:0]   hi_fix,
  output logic        [WIDTH-1:0]   lo_fix
);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  logic [2*WIDTH-1:0] prod_fix;

  // The most negative operand maps to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_neg    = a_in[WIDTH-1];
    b_neg    = b_in[WIDTH-1];
    mag_a    = neg_w(a_in, a_in[WIDTH-1]);
    mag_b    = neg_w(b_in, b_in[WIDTH-1]);
    prod_fix = neg_2w(raw, neg_a ^ neg_b);
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      // Quotient truncates toward zero; remainder follows the dividend.
      lo_fix = neg_w(raw[WIDTH-1:0], neg_a ^ neg_b);
      hi_fix = neg_w(raw[2*WIDTH-1:WIDTH], neg_a);
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide responder: one bit per clock on operand
// magnitudes, sign-corrected result committed into HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic               start_ok;
  logic               accept_mult;
  logic               accept_div;
  logic               accept_dz;
  logic               last_iter;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_c;
  logic               done_c;
  logic               dz_c;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               neg_a;
  logic               neg_b;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;

  mult_div_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a_in   (bus.a_in),
    .b_in   (bus.b_in),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .a_neg  (a_neg),
    .b_neg  (b_neg),
    .is_div (state == DIV),
    .neg_a  (neg_a),
    .neg_b  (neg_b),
    .raw    (acc),
    .hi_fix (hi_fix),
    .lo_fix (lo_fix)
  );

  // Start acceptance: only between operations; multiply has priority.
  always_comb begin
    start_ok    = (state == IDLE) || (state == FINISH) || (state == DZERO);
    accept_mult = start_ok && bus.start_mult;
    accept_div  = start_ok && !bus.start_mult && bus.start_div && (bus.b_in != '0);
    accept_dz   = start_ok && !bus.start_mult && bus.start_div && (bus.b_in == '0);
    last_iter   = (cnt == CNT_W'(WIDTH));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH, DZERO: begin
        if (accept_mult)     state_nxt = MULT;
        else if (accept_div) state_nxt = DIV;
        else if (accept_dz)  state_nxt = DZERO;
        else                 state_nxt = IDLE;
      end
      MULT, DIV: if (last_iter) state_nxt = FINISH;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    dz_c   = 1'b0;
    case (state)
      MULT, DIV: busy_c = 1'b1;
      FINISH:    done_c = 1'b1;
      DZERO:     dz_c   = 1'b1;
      default:   ;
    endcase
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.div_zero = dz_c;
  assign bus.hi_out   = hi_r;
  assign bus.lo_out   = lo_r;

  // Iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? op_a : '0)};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_b};
    if (state == MULT)   acc_step = {mult_sum, acc[WIDTH-1:1]};
    else if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else                 acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Control: iteration counter and committed HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else if (accept_mult || accept_div) begin
      cnt <= '0;
    end else if ((state == MULT) || (state == DIV)) begin
      if (last_iter) begin
        hi_r <= hi_fix;
        lo_r <= lo_fix;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Datapath: operand capture and accumulator, frozen outside MULT/DIV.
  always_ff @(posedge clk) begin
    if (accept_mult || accept_div) begin
      op_a  <= mag_a;
      op_b  <= mag_b;
      neg_a <= a_neg;
      neg_b <= b_neg;
      acc   <= accept_mult ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
    end else if (((state == MULT) || (state == DIV)) && !last_iter) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  typedef struct {
    bit          dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   vectors;
  int   miscompares;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, r, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (is_mult) begin
      r  = sa * sb;
      hi = r[63:32];
      lo = r[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // Monitor: every done/div_zero pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done && bus.div_zero) chk("done_and_dz_together", 1, 0);
    if (bus.done || bus.div_zero) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_response", {bus.done, bus.div_zero}, 0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_kind_dz", bus.div_zero, e.dz);
        chk("hi_out", bus.hi_out, e.hi);
        chk("lo_out", bus.lo_out, e.lo);
      end
    end
  end

  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input int inject_n, input int reset_n);
    exp_t e;
    int n, busy_n, spurious;
    bit stable, seen;
    e.dz = 1'b0;
    if (m) model(1'b1, a, b, e.hi, e.lo);
    else if (b == 32'd0) begin
      e.dz = 1'b1;
      e.hi = model_hi;
      e.lo = model_lo;
    end else model(1'b0, a, b, e.hi, e.lo);
    sb_q.push_back(e);
    bus.start_mult = m;
    bus.start_div  = d;
    bus.a_in       = a;
    bus.b_in       = b;
    @(posedge clk);
    #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in       = $urandom;
    bus.b_in       = $urandom;
    n = 0; busy_n = 0; stable = 1'b1; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (inject_n != 0 && n == inject_n) begin
        bus.start_div = 1'b1;
        bus.a_in      = 32'd9;
        bus.b_in      = 32'd3;
      end
      if (inject_n != 0 && n == inject_n + 1) bus.start_div = 1'b0;
      if (reset_n != 0 && n == reset_n) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        chk("abort_outputs_zero", {bus.busy, bus.done, bus.div_zero, bus.hi_out, bus.lo_out}, 0);
        spurious = 0;
        repeat (40) begin
          @(negedge clk);
          if (bus.done || bus.div_zero || bus.busy) spurious++;
        end
        chk("abort_no_done", spurious, 0);
        return;
      end
      if (bus.busy) busy_n++;
      if (bus.done || bus.div_zero) seen = 1'b1;
      else if (bus.hi_out !== model_hi || bus.lo_out !== model_lo) stable = 1'b0;
    end
    chk("response_seen", seen, 1);
    chk("latency", n, e.dz ? 1 : 34);
    chk("busy_cycles", busy_n, e.dz ? 0 : 33);
    chk("hilo_hold", stable, 1);
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] edge_vals [6];
    int kind;
    vectors = 0; miscompares = 0;
    model_hi = '0; model_lo = '0;
    edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'hFFFF_FFFF; edge_vals[2] = 32'h0;
    edge_vals[3] = 32'h1;         edge_vals[4] = 32'h7FFF_FFFF; edge_vals[5] = 32'hFFFF_FFFE;
    reset = 1'b1;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_dz", bus.div_zero, 0);
    chk("reset_hi", bus.hi_out, 0);
    chk("reset_lo", bus.lo_out, 0);

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(0, 1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op(0, 1, 32'h451, 32'h20, 0, 0);
    run_op(0, 1, 32'd5, 32'd0, 0, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(1, 0, 32'd123456, 32'hFFFF_FCEB, 10, 0);
    run_op(1, 1, 32'd6, 32'd3, 0, 0);
    run_op(1, 0, 32'd12345, 32'd678, 0, 15);
    run_op(1, 0, 32'd2, 32'd3, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      kind = $urandom_range(0, 2);
      if (kind == 2) rb = 32'd0;
      run_op(kind == 0, kind != 0, ra, rb, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential responder for the MULT/DIV requests issued by the multicycle control unit.
- Accepts a one-cycle start pulse with operands from registers A/B, iterates one bit per clock, and returns results in HI/LO.
- Returns a one-cycle done pulse, or a div_zero flag for the division-by-zero exception path.
- HI/LO outputs feed the register-data mux, replacing the constant-zero HI/LO placeholders.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start_mult  in  1  one-cycle request: signed a_in*b_in
- start_div  in  1  one-cycle request: signed a_in/b_in
- a_in  in  WIDTH  multiplicand / dividend (register A)
- b_in  in  WIDTH  multiplier / divisor (register B)
- hi_out  out  WIDTH  HI register: product upper half / remainder
- lo_out  out  WIDTH  LO register: product lower half / quotient
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when results are committed
- div_zero  out  1  one-cycle pulse: divide request had b_in==0

Behaviour:
- Reset (synchronous, active-high, one clock, clk, reset):
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, state=IDLE, iteration counter=0.
  - Reset asserted mid-operation aborts the operation; no done is ever produced for it.
- States:
  - IDLE -> MULT on start_mult.
  - IDLE -> DIV on start_div with b_in!=0.
  - IDLE -> DZERO on start_div with b_in==0.
  - MULT/DIV -> FINISH after WIDTH iterations.
  - FINISH/DZERO -> IDLE, or directly into a new operation if a start is sampled that cycle.
- Start acceptance:
  - Starts are sampled only in IDLE, FINISH or DZERO.
  - Starts during MULT/DIV are ignored, with no effect on the operation in flight.
  - start_mult and start_div together: mult wins, div is dropped.
  - Operands are captured on the accepting edge; later changes to a_in/b_in have no effect.
- Arithmetic:
  - Both operations work on signed two's complement operands.
  - Magnitudes are taken at capture, and the result sign is fixed up in the FINISH commit.
  - Multiply: shift-add over WIDTH cycles on a 2*WIDTH accumulator; {hi_out,lo_out} = full signed product.
  - Divide: restoring division over WIDTH cycles.
  - lo_out = quotient, truncated toward zero.
  - hi_out = remainder, with the sign of the dividend.
  - Special case 0x80000000 / -1: lo_out=0x80000000, hi_out=0, no flag.
- Latency:
  - Accepting edge = E0. busy=1 from after E0 through E_WIDTH.
  - hi_out/lo_out update on edge E_(WIDTH+1) (E33 for the default width).
  - In the cycle after E33, done=1 and busy=0.
- Divide by zero:
  - div_zero=1 and done=0 in the cycle after E0; busy never rises.
  - hi_out/lo_out keep their previous values.
- Output stability:
  - hi_out/lo_out change only at commit or reset.
  - Intermediate accumulators are internal; HI/LO hold the old results throughout an operation.
- done and div_zero are never high together, and each lasts exactly one cycle.

Decomposition:
- Shared package holds:
  - state enum {IDLE, MULT, DIV, FINISH, DZERO}
  - WIDTH default
  - counter width = clog2(WIDTH)+1
- Sub-module: mult_div_signfix, a combinational block that computes the magnitudes of the operands and the final sign correction. It is shared by both operations and unit-testable alone.
- The iteration datapath stays in the top module.

Test Plan:
- start_mult, a=7, b=-3 (0xFFFFFFFD) -> done exactly 34 cycles after the start cycle; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for 33 cycles.
- start_div, a=-7, b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then a=7, b=-2 -> lo_out=0xFFFFFFFD, hi_out=0x00000001.
- start_div, a=5, b=0 with HI/LO previously 0x11/0x22 -> div_zero pulse next cycle; done=0, busy=0; HI/LO stay 0x11/0x22.
- start_div, a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. Also start_mult 0x80000000*0x80000000 -> hi_out=0x40000000, lo_out=0.
- Mult in progress (cycle 10), pulse start_div with a=9, b=3 -> ignored; mult result unchanged. Simultaneous start_mult+start_div, a=6, b=3 -> product 18, no division.
- reset at cycle 15 of a mult -> all outputs 0 next cycle, no done. A new start_mult afterwards, a=2, b=3 -> lo_out=6.
